// File: rtl/reflet_float_issue.sv
// Issue/writeback stage in front of the FPU arithmetic unit: owns the float register file,
// latches operands for one command at a time and writes the result back.
// Optional watchdog abort: define REFLET_FPU_TIMEOUT_EN.
module reflet_float_issue #(
  parameter int unsigned float_size     = 32,
  parameter int unsigned reg_count      = 16,
  parameter int unsigned timeout_cycles = 255
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [5:0]                   cmd_opcode,
  input  logic [$clog2(reg_count)-1:0] cmd_dst,
  input  logic [$clog2(reg_count)-1:0] cmd_src1,
  input  logic [$clog2(reg_count)-1:0] cmd_src2,
  input  logic [$clog2(reg_count)-1:0] cmd_src3,
  output logic                         done,
  output logic                         error,
  input  logic                         error_clr,
  output logic                         flag,
  input  logic                         ext_wr_en,
  input  logic [$clog2(reg_count)-1:0] ext_wr_addr,
  input  logic [float_size-1:0]        ext_wr_data,
  input  logic [$clog2(reg_count)-1:0] ext_rd_addr,
  output logic [float_size-1:0]        ext_rd_data,
  output logic                         au_enable,
  output logic [5:0]                   au_opcode,
  output logic [float_size-1:0]        au_in1,
  output logic [float_size-1:0]        au_in2,
  output logic [float_size-1:0]        au_in3,
  input  logic [float_size-1:0]        au_out,
  input  logic                         au_flag,
  input  logic                         au_ready
);

  localparam int unsigned AddrW = $clog2(reg_count);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e                  state_q;
  logic [float_size-1:0]   regs_q [reg_count];
  logic [5:0]              opcode_q;
  logic [AddrW-1:0]        dst_q;
  logic [float_size-1:0]   in1_q, in2_q, in3_q;
  logic                    flag_q;
  logic                    abort;

`ifdef REFLET_FPU_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(timeout_cycles + 1);

  logic [CntW-1:0] cnt_q;
  logic            error_q;

  // Counter holds 0 outside RUN, so the first RUN cycle sees 0.
  assign abort = (state_q == StRun) && !au_ready && (32'(cnt_q) == timeout_cycles - 1);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q   <= '0;
      error_q <= 1'b0;
    end else begin
      if (state_q == StRun) cnt_q <= cnt_q + CntW'(1);
      else                  cnt_q <= '0;
      if (abort)          error_q <= 1'b1;
      else if (error_clr) error_q <= 1'b0;
    end
  end

  assign error = error_q;
`else
  logic unused_timeout;

  assign abort          = 1'b0;
  assign error          = 1'b0;
  assign unused_timeout = error_clr | (timeout_cycles == 0);
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      opcode_q <= '0;
      dst_q    <= '0;
      in1_q    <= '0;
      in2_q    <= '0;
      in3_q    <= '0;
      flag_q   <= 1'b0;
      for (int unsigned i = 0; i < reg_count; i++) regs_q[i] <= '0;
    end else begin
      // The writeback below is scheduled later, so it wins an index collision.
      if (ext_wr_en) regs_q[ext_wr_addr] <= ext_wr_data;
      unique case (state_q)
        StIdle: begin
          if (cmd_valid) begin
            opcode_q <= cmd_opcode;
            dst_q    <= cmd_dst;
            in1_q    <= regs_q[cmd_src1];
            in2_q    <= regs_q[cmd_src2];
            in3_q    <= regs_q[cmd_src3];
            state_q  <= StRun;
          end
        end
        StRun: begin
          if (au_ready) begin
            regs_q[dst_q] <= au_out;
            flag_q        <= au_flag;
            state_q       <= StDone;
          end else if (abort) begin
            state_q <= StDone;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign au_enable   = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign flag        = flag_q;
  assign au_opcode   = opcode_q;
  assign au_in1      = in1_q;
  assign au_in2      = in2_q;
  assign au_in3      = in3_q;
  assign ext_rd_data = regs_q[ext_rd_addr];

endmodule
